// File: rtl/exm_pipe.sv
`default_nettype none
// =====================================================================
// Module   : exm_pipe
// Purpose  : Execute stage: ALU result and branch decision with a
//            valid/ready handshake, flush and optional serial shifter.
// Revision : 1.0  initial release
// =====================================================================
module exm_pipe #(
  parameter int XLEN         = 32,
  parameter int OFFSET_W     = 20,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                input_valid_i,
  output logic                input_ready_o,
  input  logic [XLEN-1:0]     alu_operand1_i,
  input  logic [XLEN-1:0]     alu_operand2_i,
  input  logic [2:0]          alu_op_i,
  input  logic                alu_sub_i,
  input  logic                alu_shift_left_i,
  input  logic                alu_signed_shift_i,
  input  logic [2:0]          branch_cond_i,
  input  logic [OFFSET_W-1:0] branch_offset_i,
  input  logic                result_write_i,
  input  logic [4:0]          result_addr_i,
  input  logic                output_ready_i,
  output logic                output_valid_o,
  output logic [XLEN-1:0]     result_o,
  output logic                branch_o,
  output logic [OFFSET_W-1:0] branch_offset_o,
  output logic                result_write_o,
  output logic [4:0]          result_addr_o
);

  localparam int c_SHAMT_W = $clog2(XLEN);

  localparam logic [2:0] c_ALU_ADD   = 3'd0;
  localparam logic [2:0] c_ALU_XOR   = 3'd1;
  localparam logic [2:0] c_ALU_OR    = 3'd2;
  localparam logic [2:0] c_ALU_AND   = 3'd3;
  localparam logic [2:0] c_ALU_SLT   = 3'd4;
  localparam logic [2:0] c_ALU_SLTU  = 3'd5;
  localparam logic [2:0] c_ALU_SHIFT = 3'd6;

  localparam logic [2:0] c_BR_BEQ  = 3'd1;
  localparam logic [2:0] c_BR_BNE  = 3'd2;
  localparam logic [2:0] c_BR_BLT  = 3'd3;
  localparam logic [2:0] c_BR_BGE  = 3'd4;
  localparam logic [2:0] c_BR_BLTU = 3'd5;
  localparam logic [2:0] c_BR_BGEU = 3'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_SHAMT_W-1:0]  w_shamt;
  logic                  w_negate;
  logic [XLEN-1:0]       w_operand2;
  logic [XLEN-1:0]       w_sum;
  logic                  w_slt;
  logic                  w_sltu;
  logic [XLEN-1:0]       w_shift;
  logic [XLEN-1:0]       w_alu_result;
  logic                  w_branch;
  logic                  w_accept;
  logic                  w_serial_start;
  logic [XLEN-1:0]       w_step;
  logic                  w_last;

  assign input_ready_o = ~rst_i & (r_state == S_IDLE) & (~output_valid_o | output_ready_i);
  // Flush wins over a pending request: nothing is taken on a flush edge.
  assign w_accept = input_valid_i & input_ready_o & ~flush_i;

  assign w_shamt    = alu_operand2_i[c_SHAMT_W-1:0];
  assign w_negate   = alu_sub_i | (branch_cond_i == c_BR_BEQ) | (branch_cond_i == c_BR_BNE);
  assign w_operand2 = w_negate ? ~alu_operand2_i : alu_operand2_i;
  assign w_sum      = alu_operand1_i + w_operand2 + XLEN'(w_negate);
  assign w_slt      = $signed(alu_operand1_i) < $signed(alu_operand2_i);
  assign w_sltu     = alu_operand1_i < alu_operand2_i;

  generate
    if (SERIAL_SHIFT != 0) begin : g_serial
      logic [XLEN-1:0]      r_shift;
      logic [c_SHAMT_W-1:0] r_count;
      logic                 r_left;
      logic                 r_arith;

      // Amounts of 0 or 1 finish in one cycle through a single-step shifter.
      assign w_shift = (w_shamt == '0) ? alu_operand1_i :
                       alu_shift_left_i ? {alu_operand1_i[XLEN-2:0], 1'b0} :
                       {alu_signed_shift_i & alu_operand1_i[XLEN-1], alu_operand1_i[XLEN-1:1]};
      assign w_serial_start = (alu_op_i == c_ALU_SHIFT) && (w_shamt > c_SHAMT_W'(1));
      assign w_step = r_left ? {r_shift[XLEN-2:0], 1'b0} :
                      {r_arith & r_shift[XLEN-1], r_shift[XLEN-1:1]};
      assign w_last = (r_count == c_SHAMT_W'(1));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_shift <= '0;
          r_count <= '0;
          r_left  <= 1'b0;
          r_arith <= 1'b0;
        end else if (flush_i) begin
          r_count <= '0;
        end else if (r_state == S_BUSY) begin
          r_shift <= w_step;
          r_count <= r_count - c_SHAMT_W'(1);
        end else if (w_accept && w_serial_start) begin
          r_shift <= alu_operand1_i;
          r_count <= w_shamt;
          r_left  <= alu_shift_left_i;
          r_arith <= alu_signed_shift_i;
        end
      end
    end else begin : g_barrel
      assign w_shift = alu_shift_left_i ? (alu_operand1_i << w_shamt) :
                       alu_signed_shift_i ? $unsigned($signed(alu_operand1_i) >>> w_shamt) :
                       (alu_operand1_i >> w_shamt);
      assign w_serial_start = 1'b0;
      assign w_step         = '0;
      assign w_last         = 1'b0;
    end
  endgenerate

  always_comb begin
    w_alu_result = '0;
    case (alu_op_i)
      c_ALU_ADD:   w_alu_result = w_sum;
      c_ALU_XOR:   w_alu_result = alu_operand1_i ^ alu_operand2_i;
      c_ALU_OR:    w_alu_result = alu_operand1_i | alu_operand2_i;
      c_ALU_AND:   w_alu_result = alu_operand1_i & alu_operand2_i;
      c_ALU_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, w_slt};
      c_ALU_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, w_sltu};
      c_ALU_SHIFT: w_alu_result = w_shift;
      default:     w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_branch = 1'b0;
    case (branch_cond_i)
      c_BR_BEQ:  w_branch = (w_sum == '0);
      c_BR_BNE:  w_branch = (w_sum != '0);
      c_BR_BLT:  w_branch = w_slt;
      c_BR_BGE:  w_branch = ~w_slt;
      c_BR_BLTU: w_branch = w_sltu;
      c_BR_BGEU: w_branch = ~w_sltu;
      default:   w_branch = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_serial_start) w_state_next = S_BUSY;
      S_BUSY:  if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush_i) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      output_valid_o  <= 1'b0;
      result_o        <= '0;
      branch_o        <= 1'b0;
      branch_offset_o <= '0;
      result_write_o  <= 1'b0;
      result_addr_o   <= '0;
    end else if (flush_i) begin
      output_valid_o <= 1'b0;
      result_write_o <= 1'b0;
      branch_o       <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (w_last) begin
        result_o       <= w_step;
        output_valid_o <= 1'b1;
      end
    end else if (w_accept) begin
      // Passthrough fields are latched now; a serial shift fills result_o later.
      branch_o        <= w_branch;
      branch_offset_o <= branch_offset_i;
      result_write_o  <= result_write_i;
      result_addr_o   <= result_addr_i;
      if (w_serial_start) begin
        output_valid_o <= 1'b0;
      end else begin
        result_o       <= w_alu_result;
        output_valid_o <= 1'b1;
      end
    end else if (output_valid_o && output_ready_i) begin
      output_valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exm_pipe.sv
`default_nettype none
// =====================================================================
// Module   : tb_exm_pipe
// Purpose  : Scoreboard bench for exm_pipe (32-bit barrel, 32-bit serial,
//            64-bit barrel instances).
// Revision : 1.0  initial release
// =====================================================================
module tb_exm_pipe;

  localparam logic [2:0] A_ADD = 3'd0, A_XOR = 3'd1, A_OR = 3'd2, A_AND = 3'd3;
  localparam logic [2:0] A_SLT = 3'd4, A_SLTU = 3'd5, A_SH = 3'd6, A_BAD = 3'd7;
  localparam logic [2:0] B_NONE = 3'd0, B_EQ = 3'd1, B_NE = 3'd2, B_LT = 3'd3;
  localparam logic [2:0] B_GE = 3'd4, B_LTU = 3'd5, B_GEU = 3'd6;
  // flag bundles {sub, shift_left, signed_shift}
  localparam logic [2:0] F_NONE = 3'b000, F_SUB = 3'b100, F_SLL = 3'b010;
  localparam logic [2:0] F_SRL = 3'b000, F_SRA = 3'b001;

  typedef struct packed {
    logic [63:0] res;
    logic        br;
    logic [19:0] off;
    logic        wr;
    logic [4:0]  ad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, oready;
  logic [2:0]  vin;
  logic [63:0] op1, op2;
  logic [2:0]  aop, cond;
  logic        sub, sl, ss, wr;
  logic [19:0] off;
  logic [4:0]  addr;

  logic        ir0, ov0, br0, wr0, ir1, ov1, br1, wr1, ir2, ov2, br2, wr2;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [19:0] off0, off1, off2;
  logic [4:0]  ad0, ad1, ad2;

  exp_t q0[$], q1[$], q2[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exm_pipe #(.XLEN(32), .OFFSET_W(20), .SERIAL_SHIFT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .input_valid_i(vin[0]), .input_ready_o(ir0),
    .alu_operand1_i(op1[31:0]), .alu_operand2_i(op2[31:0]), .alu_op_i(aop), .alu_sub_i(sub),
    .alu_shift_left_i(sl), .alu_signed_shift_i(ss), .branch_cond_i(cond), .branch_offset_i(off),
    .result_write_i(wr), .result_addr_i(addr), .output_ready_i(oready), .output_valid_o(ov0),
    .result_o(res0), .branch_o(br0), .branch_offset_o(off0), .result_write_o(wr0), .result_addr_o(ad0));

  exm_pipe #(.XLEN(32), .OFFSET_W(20), .SERIAL_SHIFT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .input_valid_i(vin[1]), .input_ready_o(ir1),
    .alu_operand1_i(op1[31:0]), .alu_operand2_i(op2[31:0]), .alu_op_i(aop), .alu_sub_i(sub),
    .alu_shift_left_i(sl), .alu_signed_shift_i(ss), .branch_cond_i(cond), .branch_offset_i(off),
    .result_write_i(wr), .result_addr_i(addr), .output_ready_i(oready), .output_valid_o(ov1),
    .result_o(res1), .branch_o(br1), .branch_offset_o(off1), .result_write_o(wr1), .result_addr_o(ad1));

  exm_pipe #(.XLEN(64), .OFFSET_W(20), .SERIAL_SHIFT(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .input_valid_i(vin[2]), .input_ready_o(ir2),
    .alu_operand1_i(op1), .alu_operand2_i(op2), .alu_op_i(aop), .alu_sub_i(sub),
    .alu_shift_left_i(sl), .alu_signed_shift_i(ss), .branch_cond_i(cond), .branch_offset_i(off),
    .result_write_i(wr), .result_addr_i(addr), .output_ready_i(oready), .output_valid_o(ov2),
    .result_o(res2), .branch_o(br2), .branch_offset_o(off2), .result_write_o(wr2), .result_addr_o(ad2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  task automatic mon(input int d, input logic [63:0] r, input logic [26:0] f);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected output: got %h want none", d, r);
    end else begin
      if (d == 0)      e = q0.pop_front();
      else if (d == 1) e = q1.pop_front();
      else             e = q2.pop_front();
      chk($sformatf("dut%0d result", d), r, e.res);
      chk($sformatf("dut%0d fields", d), 64'(f), 64'({e.br, e.off, e.wr, e.ad}));
    end
  endtask

  // Monitor: every output transfer is matched against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (!rst && oready) begin
      if (ov0) mon(0, {32'd0, res0}, {br0, off0, wr0, ad0});
      if (ov1) mon(1, {32'd0, res1}, {br1, off1, wr1, ad1});
      if (ov2) mon(2, res2, {br2, off2, wr2, ad2});
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input int d, input logic [2:0] op, input logic [2:0] c, input logic [2:0] fl,
                       input logic [63:0] x, input logic [63:0] y, input logic [19:0] o,
                       input logic w, input logic [4:0] ad, input logic push,
                       input logic [63:0] eres, input logic ebr);
    exp_t e;
    aop = op; cond = c; {sub, sl, ss} = fl; op1 = x; op2 = y; off = o; wr = w; addr = ad;
    vin = 3'b000;
    vin[d] = 1'b1;
    #1;
    for (int i = 0; i < 100 && !rdy(d); i++) begin
      @(negedge clk);
      #1;
    end
    if (!rdy(d)) begin
      checks++;
      errors++;
      $display("FAIL dut%0d accept timeout: got ready=0 want ready=1", d);
    end
    if (push) begin
      e.res = eres; e.br = ebr; e.off = o; e.wr = w; e.ad = ad;
      if (d == 0)      q0.push_back(e);
      else if (d == 1) q1.push_back(e);
      else             q2.push_back(e);
    end
    @(negedge clk);
    vin = 3'b000;
  endtask

  task automatic wait_valid1(input int budget);
    for (int i = 0; i < budget && !ov1; i++) @(negedge clk);
    chk("dut1 completion within budget", 64'(ov1), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; oready = 1'b1; vin = 3'b000;
    op1 = '0; op2 = '0; aop = A_ADD; cond = B_NONE; {sub, sl, ss} = F_NONE;
    off = '0; wr = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    chk("reset ready dut0", 64'(ir0), 64'd0);
    chk("reset ready dut1", 64'(ir1), 64'd0);
    chk("reset valid dut0", 64'(ov0), 64'd0);
    chk("reset outputs dut0", 64'({res0, br0, off0, wr0, ad0}), 64'd0);
    chk("reset result dut2", res2, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset dut0", 64'(ir0), 64'd1);
    @(negedge clk);

    // 32-bit barrel instance: arithmetic, logic, compares, shifts, branches
    issue(0, A_ADD, B_NONE, F_NONE, 64'h7FFF_FFFF, 64'h1, 20'h0, 1'b1, 5'd5, 1'b1, 64'h8000_0000, 1'b0);
    chk("add latency one cycle", 64'(ov0), 64'd1);
    issue(0, A_ADD, B_NONE, F_SUB, 64'd5, 64'd7, 20'h0, 1'b1, 5'd6, 1'b1, 64'hFFFF_FFFE, 1'b0);
    issue(0, A_ADD, B_EQ, F_NONE, 64'h1234, 64'h1234, 20'h00040, 1'b0, 5'd0, 1'b1, 64'h0, 1'b1);
    issue(0, A_ADD, B_LTU, F_NONE, 64'hFFFF_FFFF, 64'h1, 20'h00010, 1'b0, 5'd0, 1'b1, 64'h0, 1'b0);
    issue(0, A_ADD, B_LT, F_NONE, 64'hFFFF_FFFF, 64'h1, 20'h00020, 1'b0, 5'd0, 1'b1, 64'h0, 1'b1);
    issue(0, A_ADD, B_NE, F_NONE, 64'd3, 64'd3, 20'h00030, 1'b0, 5'd0, 1'b1, 64'h0, 1'b0);
    issue(0, A_ADD, B_GE, F_NONE, 64'd3, 64'hFFFF_FFFF, 20'hFFFFF, 1'b0, 5'd0, 1'b1, 64'h2, 1'b1);
    issue(0, A_ADD, B_GEU, F_NONE, 64'd3, 64'hFFFF_FFFF, 20'h00001, 1'b0, 5'd0, 1'b1, 64'h2, 1'b0);
    issue(0, A_XOR, B_NONE, F_NONE, 64'hF0F0, 64'hFF00, 20'h0, 1'b1, 5'd7, 1'b1, 64'h0FF0, 1'b0);
    issue(0, A_OR, B_NONE, F_NONE, 64'hF0F0, 64'h0F00, 20'h0, 1'b1, 5'd8, 1'b1, 64'hFFF0, 1'b0);
    issue(0, A_AND, B_NONE, F_NONE, 64'hF0F0, 64'hFF00, 20'h0, 1'b1, 5'd9, 1'b1, 64'hF000, 1'b0);
    issue(0, A_SLT, B_NONE, F_NONE, 64'hFFFF_FFFB, 64'd3, 20'h0, 1'b1, 5'd10, 1'b1, 64'h1, 1'b0);
    issue(0, A_SLTU, B_NONE, F_NONE, 64'hFFFF_FFFB, 64'd3, 20'h0, 1'b1, 5'd11, 1'b1, 64'h0, 1'b0);
    issue(0, A_SH, B_NONE, F_SLL, 64'h1, 64'd31, 20'h0, 1'b1, 5'd12, 1'b1, 64'h8000_0000, 1'b0);
    issue(0, A_SH, B_NONE, F_SRA, 64'h8000_0000, 64'd4, 20'h0, 1'b1, 5'd13, 1'b1, 64'hF800_0000, 1'b0);
    issue(0, A_SH, B_NONE, F_SRL, 64'h8000_0000, 64'h24, 20'h0, 1'b1, 5'd14, 1'b1, 64'h0800_0000, 1'b0);
    issue(0, A_BAD, B_NONE, F_NONE, 64'd5, 64'd6, 20'h0, 1'b1, 5'd15, 1'b1, 64'h0, 1'b0);
    @(negedge clk);

    // Backpressure: hold three cycles, then transfer and accept on one edge
    oready = 1'b0;
    issue(0, A_ADD, B_NONE, F_NONE, 64'd1, 64'd2, 20'h00011, 1'b1, 5'd3, 1'b1, 64'd3, 1'b0);
    repeat (3) begin
      chk("hold valid", 64'(ov0), 64'd1);
      chk("hold outputs", 64'({res0, wr0, ad0, off0}), 64'({32'd3, 1'b1, 5'd3, 20'h00011}));
      chk("hold ready low", 64'(ir0), 64'd0);
      @(negedge clk);
    end
    oready = 1'b1;
    issue(0, A_ADD, B_NONE, F_NONE, 64'd10, 64'd20, 20'h0, 1'b1, 5'd4, 1'b1, 64'd30, 1'b0);
    chk("same-edge replace valid", 64'(ov0), 64'd1);
    chk("same-edge replace result", 64'(res0), 64'd30);
    @(negedge clk);

    // Flush of a held branch result
    oready = 1'b0;
    issue(0, A_ADD, B_EQ, F_NONE, 64'd7, 64'd7, 20'h00099, 1'b1, 5'd21, 1'b0, 64'h0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush held valid", 64'(ov0), 64'd0);
    chk("flush held write/branch", 64'({wr0, br0}), 64'd0);
    #1;
    chk("flush held ready", 64'(ir0), 64'd1);
    oready = 1'b1;
    @(negedge clk);

    // Flush overrides a valid request
    aop = A_ADD; cond = B_NONE; {sub, sl, ss} = F_NONE; op1 = 64'd1; op2 = 64'd1; wr = 1'b1;
    vin = 3'b001;
    flush = 1'b1;
    @(negedge clk);
    vin = 3'b000;
    flush = 1'b0;
    chk("flush blocks accept", 64'(ov0), 64'd0);
    @(negedge clk);

    // Serial instance
    issue(1, A_SH, B_NONE, F_SRA, 64'h8000_0000, 64'd4, 20'h0, 1'b1, 5'd6, 1'b1, 64'hF800_0000, 1'b0);
    repeat (3) begin
      chk("serial busy ready low", 64'(ir1), 64'd0);
      chk("serial busy valid low", 64'(ov1), 64'd0);
      @(negedge clk);
    end
    chk("serial not early", 64'(ov1), 64'd0);
    @(negedge clk);
    chk("serial valid after 4", 64'(ov1), 64'd1);
    @(negedge clk);
    issue(1, A_SH, B_NONE, F_SRL, 64'h1234, 64'd0, 20'h0, 1'b1, 5'd7, 1'b1, 64'h1234, 1'b0);
    chk("serial shamt0 latency", 64'(ov1), 64'd1);
    issue(1, A_SH, B_NONE, F_SRA, 64'h8000_0000, 64'd1, 20'h0, 1'b1, 5'd8, 1'b1, 64'hC000_0000, 1'b0);
    chk("serial shamt1 latency", 64'(ov1), 64'd1);
    issue(1, A_ADD, B_NONE, F_NONE, 64'd2, 64'd3, 20'h0, 1'b1, 5'd9, 1'b1, 64'd5, 1'b0);
    issue(1, A_SH, B_NONE, F_SLL, 64'h1, 64'd31, 20'h0, 1'b1, 5'd10, 1'b1, 64'h8000_0000, 1'b0);
    wait_valid1(40);
    @(negedge clk);

    // Flush mid-BUSY
    issue(1, A_SH, B_NONE, F_SLL, 64'h1, 64'd10, 20'h0, 1'b1, 5'd11, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy valid", 64'(ov1), 64'd0);
    chk("flush busy write", 64'(wr1), 64'd0);
    #1;
    chk("flush busy ready", 64'(ir1), 64'd1);
    repeat (12) @(negedge clk);
    chk("flush busy no completion", 64'(ov1), 64'd0);

    // Reset mid-BUSY
    issue(1, A_SH, B_NONE, F_SLL, 64'h1, 64'd10, 20'h00055, 1'b1, 5'd9, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy valid", 64'(ov1), 64'd0);
    chk("rst busy outputs", 64'({res1, br1, off1, wr1, ad1}), 64'd0);
    chk("rst busy ready", 64'(ir1), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready after rst busy", 64'(ir1), 64'd1);
    repeat (12) @(negedge clk);
    chk("rst busy no completion", 64'(ov1), 64'd0);

    // 64-bit instance
    issue(2, A_ADD, B_NONE, F_NONE, 64'hFFFF_FFFF, 64'h1, 20'h0, 1'b1, 5'd1, 1'b1, 64'h1_0000_0000, 1'b0);
    issue(2, A_ADD, B_NONE, F_SUB, 64'd5, 64'd7, 20'h0, 1'b1, 5'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    issue(2, A_SH, B_NONE, F_SRA, 64'h8000_0000_0000_0000, 64'd36, 20'h0, 1'b1, 5'd3, 1'b1,
          64'hFFFF_FFFF_F800_0000, 1'b0);
    issue(2, A_SLT, B_NONE, F_NONE, 64'hFFFF_FFFF, 64'h1, 20'h0, 1'b1, 5'd4, 1'b1, 64'h0, 1'b0);
    issue(2, A_ADD, B_LTU, F_NONE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 20'h00040, 1'b0, 5'd0, 1'b1, 64'h0, 1'b0);
    issue(2, A_ADD, B_LT, F_NONE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 20'h00040, 1'b0, 5'd0, 1'b1, 64'h0, 1'b1);
    repeat (3) @(negedge clk);

    chk("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
    chk("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
    chk("dut2 scoreboard drained", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
